// File: rtl/demux_1to2_buffered.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream steered by in_sel
// into one of two small per-output FIFOs, each drained by its own consumer.
module demux_1to2_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);

  localparam int PW = $clog2(DEPTH);

  logic [1:0][CW-1:0]    w_count;
  logic [1:0][WIDTH-1:0] w_head;
  logic [1:0]            w_valid;
  logic [1:0]            w_out_ready;

  assign w_out_ready = {out1_ready, out0_ready};

  // Accept decision depends only on registered occupancy, so a full FIFO
  // never accepts even while it drains on the same edge.
  assign in_ready = (w_count[in_sel] != CW'(DEPTH));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wr_ptr;
      logic [PW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;
      logic             w_push;
      logic             w_pop;

      assign w_push       = in_valid && in_ready && (in_sel == 1'(gi));
      assign w_pop        = w_valid[gi] && w_out_ready[gi];
      assign w_valid[gi]  = (r_count != '0);
      assign w_count[gi]  = r_count;
      assign w_head[gi]   = r_mem[r_rd_ptr];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end

      a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        r_count <= CW'(DEPTH));
      a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(w_pop && !w_push && (r_count == '0)));
    end
  endgenerate

  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_count = w_count[0];
  assign out1_count = w_count[1];

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed self-checking bench for demux_1to2_buffered (DEPTH=2, WIDTH=32).
module tb_demux_1to2_buffered;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    out0_count;
  logic [CW-1:0]    out1_count;

  int n_cmp;
  int n_bad;

  demux_1to2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_valid0", 32'(out0_valid), 32'd0);
    chk("rst_valid1", 32'(out1_valid), 32'd0);
    chk("rst_count0", 32'(out0_count), 32'd0);
    chk("rst_count1", 32'(out1_count), 32'd0);
    chk("rst_data0",  out0_data, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_valid0", 32'(out0_valid), 32'd0);
    chk("idle_valid1", 32'(out1_valid), 32'd0);
    chk("idle_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    chk("idle_ready_sel1", 32'(in_ready), 32'd1);

    // Single beat to out0
    in_sel = 1'b0; in_data = 32'h0000_0005; in_valid = 1'b1; out0_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid0", 32'(out0_valid), 32'd1);
    chk("single_data0",  out0_data, 32'h5);
    chk("single_count0", 32'(out0_count), 32'd1);
    chk("single_count1", 32'(out1_count), 32'd0);
    step();
    chk("single_drained_count0", 32'(out0_count), 32'd0);
    chk("single_drained_valid0", 32'(out0_valid), 32'd0);

    // Fill out0 with consumer stalled, then divert to out1
    out0_ready = 1'b0;
    in_sel = 1'b0; in_data = 32'd9; in_valid = 1'b1;
    step();
    in_data = 32'd10;
    step();
    in_valid = 1'b0;
    #1;
    chk("fill_count0", 32'(out0_count), 32'd2);
    chk("fill_ready_sel0", 32'(in_ready), 32'd0);
    chk("fill_head0", out0_data, 32'd9);
    in_sel = 1'b1; in_data = 32'd7; in_valid = 1'b1;
    #1;
    chk("fill_ready_sel1", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("fill_data1",  out1_data, 32'd7);
    chk("fill_count1", 32'(out1_count), 32'd1);
    out0_ready = 1'b1;
    step();
    chk("drain_second0", out0_data, 32'd10);
    chk("drain_count0",  32'(out0_count), 32'd1);
    step();
    chk("drain_empty0", 32'(out0_count), 32'd0);
    out0_ready = 1'b0;

    // Simultaneous push and pop on out1 (holding 7)
    in_sel = 1'b1; in_data = 32'd3; in_valid = 1'b1; out1_ready = 1'b1;
    step();
    in_valid = 1'b0; out1_ready = 1'b0;
    chk("pushpop_count1", 32'(out1_count), 32'd1);
    chk("pushpop_head1",  out1_data, 32'd3);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    chk("pushpop_drained1", 32'(out1_count), 32'd0);

    // Wrap-around streaming into out0
    out0_ready = 1'b1; in_sel = 1'b0;
    for (int v = 1; v <= 7; v++) begin
      in_data = 32'(v); in_valid = 1'b1;
      #1;
      chk($sformatf("wrap_ready_%0d", v), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("wrap_data_%0d", v),  out0_data, 32'(v));
      chk($sformatf("wrap_count_%0d", v), 32'(out0_count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("wrap_final_count0", 32'(out0_count), 32'd0);

    // Cross traffic alternating destinations
    out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 1'(i % 2); in_data = 32'(20 + i); in_valid = 1'b1;
      #1;
      chk($sformatf("cross_ready_%0d", i), 32'(in_ready), 32'd1);
      step();
      if ((i % 2) == 0) begin
        chk($sformatf("cross_out0_%0d", i), out0_data, 32'(20 + i));
        chk($sformatf("cross_cnt0_%0d", i), 32'(out0_count), 32'd1);
      end else begin
        chk($sformatf("cross_out1_%0d", i), out1_data, 32'(20 + i));
        chk($sformatf("cross_cnt1_%0d", i), 32'(out1_count), 32'd1);
      end
    end
    in_valid = 1'b0;
    step();
    chk("cross_final_count0", 32'(out0_count), 32'd0);
    chk("cross_final_count1", 32'(out1_count), 32'd0);
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset mid-run with two entries held in out1
    in_sel = 1'b1; in_data = 32'd11; in_valid = 1'b1;
    step();
    in_data = 32'd12;
    step();
    in_valid = 1'b0;
    chk("prereset_count1", 32'(out1_count), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_valid1", 32'(out1_valid), 32'd0);
    chk("midrst_count1", 32'(out1_count), 32'd0);
    chk("midrst_data1",  out1_data, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("postrst_count1", 32'(out1_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
